// File: rtl/layer_data_loader_if.sv
// Stream-in / memory-write bundle for the layer data loader.
// The loader side (master) accepts stream words and drives the memory write
// port; the environment side (slave) supplies the stream and observes writes.
interface layer_data_loader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int SEL_W  = 2
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [SEL_W-1:0]  mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_sel, mem_addr, mem_data
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_sel, mem_addr, mem_data
    );
endinterface

// File: rtl/layer_data_loader.sv
// Load sequencer: streams words into the CNN weight, FC weight and image
// memories in region order. Each region has its own base address and word
// count; zero-length regions are skipped. Abort cancels the load and sets a
// sticky error flag; a completed load gives a single-cycle done pulse.
module layer_data_loader #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int NUM_REGIONS = 3,
    parameter int SEL_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic                          abort,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0] region_len,
    layer_data_loader_if.master           bus,
    output logic [NUM_REGIONS-1:0]        region_done,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STREAM,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_R = SEL_W'(NUM_REGIONS - 1);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       r_q, r_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [ADDR_W-1:0]      len_q, len_d;
    logic [ADDR_W-1:0]      count_q, count_d;
    logic [NUM_REGIONS-1:0] region_done_q, region_done_d;
    logic                   err_q, err_d;
    logic                   mem_we_q, mem_we_d;
    logic [SEL_W-1:0]       mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_data_q, mem_data_d;

    logic [ADDR_W-1:0]      cur_base;
    logic [ADDR_W-1:0]      cur_len;
    logic                   in_ready_w;
    logic                   beat;

    // Base/length of the region currently being set up.
    assign cur_base = region_base[r_q*ADDR_W +: ADDR_W];
    assign cur_len  = region_len[r_q*ADDR_W +: ADDR_W];

    // Abort blocks acceptance in the same cycle it is raised.
    assign in_ready_w = (state_q == S_STREAM) && !abort;
    assign beat       = bus.in_valid && in_ready_w;

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        // NOTE: every _d gets a default first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d       = state_q;
        r_d           = r_q;
        base_d        = base_q;
        len_d         = len_q;
        count_d       = count_q;
        region_done_d = region_done_q;
        err_d         = err_q;
        mem_we_d      = 1'b0;
        mem_sel_d     = mem_sel_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d       = S_SETUP;
                    region_done_d = '0;
                    err_d         = 1'b0;
                    r_d           = '0;
                end
            end
            S_SETUP: begin
                base_d  = cur_base;
                len_d   = cur_len;
                count_d = '0;
                if (cur_len == '0) begin
                    region_done_d[r_q] = 1'b1;
                    state_d            = S_NEXT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat) begin
                    mem_we_d   = 1'b1;
                    mem_sel_d  = r_q;
                    mem_addr_d = base_q + count_q;  // wraps modulo 2**ADDR_W
                    mem_data_d = bus.in_data;
                    count_d    = count_q + ADDR_W'(1);
                    if (count_q == len_q - ADDR_W'(1)) begin
                        region_done_d[r_q] = 1'b1;
                        state_d            = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (r_q == LAST_R) begin
                    state_d = S_DONE;
                end else begin
                    r_d     = r_q + SEL_W'(1);
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything outside IDLE; completed-region flags are
        // kept, but a zero-length skip decided in this same cycle is not.
        if (abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            err_d         = 1'b1;
            region_done_d = region_done_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            r_q           <= '0;
            base_q        <= '0;
            len_q         <= '0;
            count_q       <= '0;
            region_done_q <= '0;
            err_q         <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_sel_q     <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            r_q           <= r_d;
            base_q        <= base_d;
            len_q         <= len_d;
            count_q       <= count_d;
            region_done_q <= region_done_d;
            err_q         <= err_d;
            mem_we_q      <= mem_we_d;
            mem_sel_q     <= mem_sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
        end
    end

    assign bus.in_ready = in_ready_w;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_sel  = mem_sel_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;

    assign region_done = region_done_q;
    assign err         = err_q;
    assign busy        = (state_q == S_SETUP) || (state_q == S_STREAM) || (state_q == S_NEXT);
    assign done        = (state_q == S_DONE) && !abort;

endmodule
